// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: circular instruction/PC queue between fetch and decode.
// Handshakes are valid/ready on both sides. The queue supports flush, a halted
// freeze, and presents NOP/0 when nothing is valid.
// Optional macro FDQ_BYPASS_EN: when the queue is empty, a push is forwarded
// to pop_* in the same cycle.
module fetch_decode_queue #(
  parameter int unsigned            INSTR_W = 32,
  parameter int unsigned            PC_W    = 32,
  parameter int unsigned            DEPTH   = 4,
  parameter logic [INSTR_W-1:0]     NOP     = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         halted,
  input  logic                         flush,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [INSTR_W-1:0]           push_instr,
  input  logic [PC_W-1:0]              push_pc,
  output logic                         pop_valid,
  input  logic                         pop_ready,
  output logic [INSTR_W-1:0]           pop_instr,
  output logic [PC_W-1:0]              pop_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [INSTR_W-1:0] instr_mem_d [DEPTH];
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [PC_W-1:0]    pc_mem_d    [DEPTH];

  logic full, empty;
  logic push_fire, pop_fire;
  logic bypass_take;
  logic wr_en, rd_en;

  // Status flags and handshake outputs; pop side is register-driven unless bypassing.
  always_comb begin
    full        = (count_q == CNT_W'(DEPTH));
    empty       = (count_q == '0);
    push_ready  = !full && !halted;
    count       = count_q;
    almost_full = (count_q >= CNT_W'(DEPTH - 1));
    pop_valid   = !empty && !halted;
    pop_instr   = NOP;
    pop_pc      = '0;
    bypass_take = 1'b0;
    if (pop_valid) begin
      pop_instr = instr_mem_q[rd_ptr_q];
      pop_pc    = pc_mem_q[rd_ptr_q];
    end
`ifdef FDQ_BYPASS_EN
    else if (empty && push_valid && !flush && !halted) begin
      pop_valid   = 1'b1;
      pop_instr   = push_instr;
      pop_pc      = push_pc;
      bypass_take = pop_ready;
    end
`endif
    push_fire = push_valid && push_ready && !flush;
    pop_fire  = pop_valid && pop_ready && !halted && !flush;
    // A bypassed entry that is consumed immediately never touches storage.
    wr_en     = push_fire && !bypass_take;
    rd_en     = pop_fire && !bypass_take;
  end

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        instr_mem_d[wr_ptr_q] = push_instr;
        pc_mem_d[wr_ptr_q]    = push_pc;
        wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (wr_en && !rd_en) begin
        count_d = count_q + 1'b1;
      end else if (rd_en && !wr_en) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful under count, so no reset.
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue (DEPTH=4) using a scoreboard queue.
module tb_fetch_decode_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic        halted;
  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_instr;
  logic [31:0] push_pc;
  logic        pop_valid;
  logic        pop_ready;
  logic [31:0] pop_instr;
  logic [31:0] pop_pc;
  logic [2:0]  count;
  logic        almost_full;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  fetch_decode_queue #(
    .INSTR_W(32),
    .PC_W(32),
    .DEPTH(DEPTH),
    .NOP(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .halted(halted),
    .flush(flush),
    .push_valid(push_valid),
    .push_ready(push_ready),
    .push_instr(push_instr),
    .push_pc(push_pc),
    .pop_valid(pop_valid),
    .pop_ready(pop_ready),
    .pop_instr(pop_instr),
    .pop_pc(pop_pc),
    .count(count),
    .almost_full(almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs against the scoreboard, then advance the model.
  task automatic step(input logic pv, input logic [31:0] pi, input logic [31:0] pp,
                      input logic pr, input logic h, input logic f);
    logic        exp_valid;
    logic [31:0] exp_instr, exp_pc;
    logic        push_ok, pop_ok, byp;
    int          sz;
    push_valid = pv;
    push_instr = pi;
    push_pc    = pp;
    pop_ready  = pr;
    halted     = h;
    flush      = f;
    #1;
    sz        = sb.size();
    exp_valid = (sz > 0) && !h;
    exp_instr = 32'h0;
    exp_pc    = 32'h0;
    byp       = 1'b0;
    if (exp_valid) begin
      exp_instr = sb[0].instr;
      exp_pc    = sb[0].pc;
    end
`ifdef FDQ_BYPASS_EN
    else if (sz == 0 && pv && !h && !f) begin
      exp_valid = 1'b1;
      exp_instr = pi;
      exp_pc    = pp;
      byp       = 1'b1;
    end
`endif
    check("pop_valid", {63'd0, pop_valid}, {63'd0, exp_valid});
    check("pop_instr", {32'd0, pop_instr}, {32'd0, exp_instr});
    check("pop_pc", {32'd0, pop_pc}, {32'd0, exp_pc});
    check("count", {61'd0, count}, 64'(sz));
    check("almost_full", {63'd0, almost_full}, {63'd0, (sz >= DEPTH - 1)});
    check("push_ready", {63'd0, push_ready}, {63'd0, (sz < DEPTH) && !h});
    push_ok = pv && (sz < DEPTH) && !h && !f;
    pop_ok  = pr && exp_valid && !h && !f;
    if (f) begin
      sb.delete();
    end else if (byp && pop_ok) begin
      // forwarded and consumed in the same cycle: nothing stored
    end else begin
      if (pop_ok) void'(sb.pop_front());
      if (push_ok) sb.push_back('{instr: pi, pc: pp});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    halted     = 1'b0;
    flush      = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb.delete();
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      step(1'b1, base + 32'(i), 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n    = 1'b0;
    halted     = 1'b0;
    flush      = 1'b0;
    push_valid = 1'b0;
    push_instr = '0;
    push_pc    = '0;
    pop_ready  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // reset state, then first push visible next cycle
    idle();
    step(1'b1, 32'h00A0_0093, 32'h100, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();

    // fill to full, refused push, then full push+pop
    push_n(4, 32'h1000_0000);
    step(1'b1, 32'hBAD0_0001, 32'h999, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hBAD0_0002, 32'h998, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();

    // continuous push+pop across pointer wrap
    step(1'b1, 32'h2000_0000, 32'h800, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++)
      step(1'b1, 32'h2000_0000 + 32'(i), 32'h800 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();

    // flush at count 3 with push and pop requested
    push_n(3, 32'h3000_0000);
    step(1'b1, 32'h3000_00FF, 32'hFFC, 1'b1, 1'b0, 1'b1);
    idle();

    // halt for 3 cycles at count 2, then resume with the same head
    push_n(2, 32'h4000_0000);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h4000_00EE, 32'hEE0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();

    // reset mid-stream drops entries
    push_n(2, 32'h5000_0000);
    do_reset();
    idle();

`ifdef FDQ_BYPASS_EN
    step(1'b1, 32'hDEAD_BEEF, 32'h200, 1'b1, 1'b0, 1'b0);
    idle();
    step(1'b1, 32'hCAFE_F00D, 32'h204, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();
`endif

    // random traffic, with occasional halt and flush
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0));
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
